// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_driver
// Description : Command stage for a bank of JK flip-flops. Computes the J/K
//               excitation for one cycle, then checks the bank's q feedback.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_driver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_ok,
  output logic [WIDTH-1:0] rsp_q,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0]       c_mode_load   = 2'b00;
  localparam logic [1:0]       c_mode_toggle = 2'b01;
  localparam logic [1:0]       c_mode_clear  = 2'b10;
  localparam logic [CNT_W-1:0] c_cnt_max     = '1;
  localparam logic [CNT_W-1:0] c_cnt_one     = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic [WIDTH-1:0] w_j_exc;
  logic [WIDTH-1:0] w_k_exc;
  logic [WIDTH-1:0] w_exp_exc;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] r_expected;
  logic             r_rsp_valid;
  logic             r_rsp_ok;
  logic [WIDTH-1:0] r_rsp_q;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_accept = cmd_valid && (r_state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_state_next = S_DRIVE;
      S_DRIVE: w_state_next = S_CHECK;
      S_CHECK: w_state_next = S_RESP;
      S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Excitation is derived from the bank value present at the accept edge.
  always_comb begin
    w_j_exc   = '0;
    w_k_exc   = '0;
    w_exp_exc = q_fb;
    case (cmd_mode)
      c_mode_load: begin
        w_j_exc   = cmd_data & ~q_fb;
        w_k_exc   = ~cmd_data & q_fb;
        w_exp_exc = cmd_data;
      end
      c_mode_toggle: begin
        w_j_exc   = cmd_data;
        w_k_exc   = cmd_data;
        w_exp_exc = q_fb ^ cmd_data;
      end
      c_mode_clear: begin
        w_k_exc   = cmd_data;
        w_exp_exc = q_fb & ~cmd_data;
      end
      default: begin
        w_j_exc   = cmd_data;
        w_exp_exc = q_fb | cmd_data;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_j         <= '0;
      r_k         <= '0;
      r_expected  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_ok    <= 1'b0;
      r_rsp_q     <= '0;
      r_err_cnt   <= '0;
    end else begin
      // J/K are live only for the DRIVE cycle that follows an accept.
      r_j <= w_accept ? w_j_exc : '0;
      r_k <= w_accept ? w_k_exc : '0;
      if (w_accept) begin
        r_expected <= w_exp_exc;
      end
      if (r_state == S_CHECK) begin
        r_rsp_valid <= 1'b1;
        r_rsp_q     <= q_fb;
        r_rsp_ok    <= (q_fb == r_expected);
        if ((q_fb != r_expected) && (r_err_cnt != c_cnt_max)) begin
          r_err_cnt <= r_err_cnt + c_cnt_one;
        end
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign j         = r_j;
  assign k         = r_k;
  assign rsp_valid = r_rsp_valid;
  assign rsp_ok    = r_rsp_ok;
  assign rsp_q     = r_rsp_q;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
